// File: rtl/llmint_pkg.sv
// Shared types and helpers for the LLMint weight path.
package llmint_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    LOADED,
    STREAM
  } streamer_state_t;

  // Number of low-order bits dropped when downcasting a weight.
  function automatic int calc_shift(input int orig_w, input int red_w);
    return orig_w - red_w;
  endfunction

  // Downcast one sign-extended weight. Truncation is a plain arithmetic
  // shift; rounding adds half an LSB first and clamps positive overflow.
  // The 32-bit working width provides the guard bit for the rounding add.
  function automatic logic signed [31:0] quantize_word(
    input logic signed [31:0] w,
    input int                 orig_w,
    input int                 red_w,
    input bit                 rnd
  );
    logic signed [31:0] sum;
    logic signed [31:0] q;
    logic signed [31:0] maxv;
    int                 s;
    s    = calc_shift(orig_w, red_w);
    maxv = (32'sd1 <<< (red_w - 1)) - 32'sd1;
    sum  = w;
    if (rnd) begin
      sum = w + (32'sd1 <<< (s - 1));
    end
    q = sum >>> s;
    if (rnd && (q > maxv)) begin
      q = maxv;
    end
    return q;
  endfunction

endpackage

// File: rtl/llmint_quantize.sv
// Combinational single-word quantizer (full precision -> reduced precision).
module llmint_quantize import llmint_pkg::*; #(
  parameter int ORIGINAL_PRECISION = 16,
  parameter int REDUCED_PRECISION  = 8,
  parameter int ROUND              = 0
) (
  input  logic signed [ORIGINAL_PRECISION-1:0] i_word,
  output logic        [REDUCED_PRECISION-1:0]  o_word
);

  // Sign-extend, downcast through the shared helper, keep the low bits.
  always_comb begin
    o_word = REDUCED_PRECISION'(quantize_word(32'(i_word), ORIGINAL_PRECISION,
                                              REDUCED_PRECISION, ROUND != 0));
  end

endmodule

// File: rtl/llmint_weight_streamer.sv
// LLMint weight transmitter: stores one weight matrix from a write stream and
// replays it row by row, full-precision and quantized, for N passes.
module llmint_weight_streamer import llmint_pkg::*; #(
  parameter int ORIGINAL_PRECISION = 16,
  parameter int REDUCED_PRECISION  = 8,
  parameter int WEIGHT_DIM_0       = 4,
  parameter int WEIGHT_DIM_1       = 4,
  parameter int ROUND              = 0,
  parameter int PASS_W             = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [ORIGINAL_PRECISION-1:0] i_wr_data,
  input  logic                          i_wr_valid,
  output logic                          o_wr_ready,
  input  logic                          i_reload,
  input  logic                          i_start,
  input  logic [PASS_W-1:0]             i_num_passes,
  output logic                          o_busy,
  output logic [ORIGINAL_PRECISION-1:0] o_weight_hp [WEIGHT_DIM_0],
  output logic [REDUCED_PRECISION-1:0]  o_weight_lp [WEIGHT_DIM_0],
  output logic                          o_weight_valid,
  input  logic                          i_weight_ready,
  output logic                          o_weight_last,
  output logic                          o_done
);

  localparam int DEPTH  = WEIGHT_DIM_0 * WEIGHT_DIM_1;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ROW_W  = (WEIGHT_DIM_1 > 1) ? $clog2(WEIGHT_DIM_1) : 1;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(WEIGHT_DIM_1 - 1);

  streamer_state_t r_state;
  streamer_state_t w_next_state;

  logic [ORIGINAL_PRECISION-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]             r_wcnt;
  logic [ROW_W-1:0]              r_row;
  logic [PASS_W-1:0]             r_pass;
  logic [PASS_W-1:0]             r_num_passes;
  logic                          r_wr_ready;
  logic                          r_valid;
  logic                          r_last;
  logic                          r_done;
  logic [ORIGINAL_PRECISION-1:0] r_hp [WEIGHT_DIM_0];
  logic [REDUCED_PRECISION-1:0]  r_lp [WEIGHT_DIM_0];

  logic                          w_wr_fire;
  logic                          w_start_acc;
  logic                          w_zero_start;
  logic                          w_reload_acc;
  logic                          w_fire;
  logic                          w_final;
  logic [ROW_W-1:0]              w_adv_row;
  logic [ROW_W-1:0]              w_next_row;
  logic [ORIGINAL_PRECISION-1:0] w_rd_hp [WEIGHT_DIM_0];
  logic [REDUCED_PRECISION-1:0]  w_rd_lp [WEIGHT_DIM_0];

  // Next-state logic and the handshake strobes that drive the datapath.
  always_comb begin
    w_next_state = r_state;
    w_wr_fire    = 1'b0;
    w_start_acc  = 1'b0;
    w_zero_start = 1'b0;
    w_reload_acc = 1'b0;
    w_fire       = 1'b0;
    w_final      = 1'b0;
    case (r_state)
      EMPTY, LOAD: begin
        w_wr_fire = i_wr_valid & r_wr_ready;
        if (w_wr_fire) begin
          w_next_state = (r_wcnt == LAST_WORD) ? LOADED : LOAD;
        end
      end
      LOADED: begin
        if (i_start) begin
          if (i_num_passes != '0) begin
            w_start_acc  = 1'b1;
            w_next_state = STREAM;
          end else begin
            w_zero_start = 1'b1;
          end
        end else if (i_reload) begin
          w_reload_acc = 1'b1;
          w_next_state = EMPTY;
        end
      end
      STREAM: begin
        w_fire  = r_valid & i_weight_ready;
        w_final = w_fire && (r_row == LAST_ROW) &&
                  (r_pass == r_num_passes - 1'b1);
        if (w_final) begin
          w_next_state = LOADED;
        end
      end
      default: w_next_state = EMPTY;
    endcase
  end

  // Row that will be presented after this cycle: row 0 on start, else advance.
  always_comb begin
    w_adv_row  = (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
    w_next_row = (r_state == STREAM) ? w_adv_row : '0;
  end

  // Fetch the words of the upcoming row from storage.
  always_comb begin
    for (int j = 0; j < WEIGHT_DIM_0; j++) begin
      w_rd_hp[j] = r_mem[ADDR_W'(int'(w_next_row) * WEIGHT_DIM_0 + j)];
    end
  end

  for (genvar g = 0; g < WEIGHT_DIM_0; g++) begin : g_quant
    llmint_quantize #(
      .ORIGINAL_PRECISION (ORIGINAL_PRECISION),
      .REDUCED_PRECISION  (REDUCED_PRECISION),
      .ROUND              (ROUND)
    ) u_quant (
      .i_word (w_rd_hp[g]),
      .o_word (w_rd_lp[g])
    );
  end

  // State register; reset aborts any load or stream immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Control counters and beat flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wcnt       <= '0;
      r_row        <= '0;
      r_pass       <= '0;
      r_num_passes <= '0;
      r_wr_ready   <= 1'b0;
      r_valid      <= 1'b0;
      r_last       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_wr_ready <= (w_next_state == EMPTY) || (w_next_state == LOAD);
      r_done     <= w_final | w_zero_start;
      if (w_wr_fire) begin
        r_wcnt <= (r_wcnt == LAST_WORD) ? '0 : r_wcnt + 1'b1;
      end else if (w_reload_acc) begin
        r_wcnt <= '0;
      end
      if (w_start_acc) begin
        r_row        <= '0;
        r_pass       <= '0;
        r_num_passes <= i_num_passes;
        r_valid      <= 1'b1;
        r_last       <= (w_next_row == LAST_ROW);
      end else if (w_final) begin
        r_row   <= '0;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else if (w_fire) begin
        r_row  <= w_next_row;
        r_last <= (w_next_row == LAST_ROW);
        if (r_row == LAST_ROW) begin
          r_pass <= r_pass + 1'b1;
        end
      end
    end
  end

  // Weight storage; not reset, the FSM forces a reload after reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_fire) begin
      r_mem[r_wcnt] <= i_wr_data;
    end
  end

  // Beat payload registers; only loaded when a new row is presented, so the
  // payload holds still while the consumer stalls.
  always_ff @(posedge i_clk) begin
    if (w_start_acc || (w_fire && !w_final)) begin
      for (int j = 0; j < WEIGHT_DIM_0; j++) begin
        r_hp[j] <= w_rd_hp[j];
        r_lp[j] <= w_rd_lp[j];
      end
    end
  end

  assign o_wr_ready     = r_wr_ready;
  assign o_busy         = (r_state == STREAM);
  assign o_weight_hp    = r_hp;
  assign o_weight_lp    = r_lp;
  assign o_weight_valid = r_valid;
  assign o_weight_last  = r_last;
  assign o_done         = r_done;

endmodule

// File: tb/tb_llmint_weight_streamer.sv
// Scoreboard bench for llmint_weight_streamer: two instances (truncating and
// rounding) share all stimulus; expected rows are queued by the stimulus and
// consumed by an independent monitor.
module tb_llmint_weight_streamer;

  localparam int OP = 16;
  localparam int RP = 8;
  localparam int D0 = 4;
  localparam int D1 = 4;
  localparam int PW = 8;

  typedef struct packed {
    logic [D0-1:0][OP-1:0] hp;
    logic [D0-1:0][RP-1:0] lpT;
    logic [D0-1:0][RP-1:0] lpR;
    logic                  last;
    logic                  fin;
  } beat_t;

  // Hand-computed quantization vectors (row-major)
  localparam logic [15:0] Q_HP [16] = '{
    16'h1234, 16'hFF80, 16'h7FFF, 16'h8000,
    16'h1280, 16'h127F, 16'h7FC0, 16'h8040,
    16'h0080, 16'hFF7F, 16'h0100, 16'hFFFF,
    16'h7F7F, 16'h7F80, 16'hC000, 16'h4000};
  localparam logic [7:0] Q_LPT [16] = '{
    8'h12, 8'hFF, 8'h7F, 8'h80,
    8'h12, 8'h12, 8'h7F, 8'h80,
    8'h00, 8'hFF, 8'h01, 8'hFF,
    8'h7F, 8'h7F, 8'hC0, 8'h40};
  localparam logic [7:0] Q_LPR [16] = '{
    8'h12, 8'h00, 8'h7F, 8'h80,
    8'h13, 8'h12, 8'h7F, 8'h80,
    8'h01, 8'hFF, 8'h01, 8'h00,
    8'h7F, 8'h7F, 8'hC0, 8'h40};

  logic          clk = 1'b0;
  logic          rstN;
  logic [OP-1:0] wrData;
  logic          wrValid;
  logic          reload;
  logic          start;
  logic [PW-1:0] numPasses;
  logic          weightReady;

  logic          wrReady, busy, wValid, wLast, done;
  logic [OP-1:0] wHp [D0];
  logic [RP-1:0] wLp [D0];
  logic          wrReadyR, busyR, wValidR, wLastR, doneR;
  logic [OP-1:0] wHpR [D0];
  logic [RP-1:0] wLpR [D0];

  beat_t expQ[$];
  int    testsRun = 0;
  int    testsFailed = 0;
  bit    randomReady = 1'b0;
  bit    doneArm = 1'b0;

  always #5 clk = ~clk;

  llmint_weight_streamer #(
    .ORIGINAL_PRECISION(OP), .REDUCED_PRECISION(RP), .WEIGHT_DIM_0(D0),
    .WEIGHT_DIM_1(D1), .ROUND(0), .PASS_W(PW)
  ) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_wr_data(wrData), .i_wr_valid(wrValid),
    .o_wr_ready(wrReady), .i_reload(reload), .i_start(start),
    .i_num_passes(numPasses), .o_busy(busy), .o_weight_hp(wHp),
    .o_weight_lp(wLp), .o_weight_valid(wValid), .i_weight_ready(weightReady),
    .o_weight_last(wLast), .o_done(done)
  );

  llmint_weight_streamer #(
    .ORIGINAL_PRECISION(OP), .REDUCED_PRECISION(RP), .WEIGHT_DIM_0(D0),
    .WEIGHT_DIM_1(D1), .ROUND(1), .PASS_W(PW)
  ) dutR (
    .i_clk(clk), .i_rst_n(rstN), .i_wr_data(wrData), .i_wr_valid(wrValid),
    .o_wr_ready(wrReadyR), .i_reload(reload), .i_start(start),
    .i_num_passes(numPasses), .o_busy(busyR), .o_weight_hp(wHpR),
    .o_weight_lp(wLpR), .o_weight_valid(wValidR), .i_weight_ready(weightReady),
    .o_weight_last(wLastR), .o_done(doneR)
  );

  // Compare one observed value with its expectation and keep the tallies
  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] wordOf(input int sel, input int i);
    return (sel == 0) ? 16'(i) : Q_HP[i];
  endfunction

  function automatic logic [7:0] lpTOf(input int sel, input int i);
    return (sel == 0) ? 8'h00 : Q_LPT[i];
  endfunction

  function automatic logic [7:0] lpROf(input int sel, input int i);
    return (sel == 0) ? 8'h00 : Q_LPR[i];
  endfunction

  // Pulse start/reload for one cycle with the given pass count
  task automatic applyStimulus(input logic st, input logic rl, input logic [PW-1:0] np);
    numPasses = np;
    start     = st;
    reload    = rl;
    @(posedge clk); #1;
    start  = 1'b0;
    reload = 1'b0;
  endtask

  // Write words first..lastIdx of a matrix, waiting (bounded) for wr_ready
  task automatic loadWords(input int sel, input int first, input int lastIdx);
    int guard;
    for (int i = first; i <= lastIdx; i++) begin
      wrData  = wordOf(sel, i);
      wrValid = 1'b1;
      guard   = 0;
      while (!(wrReady && wrReadyR) && guard < 20) begin
        @(posedge clk); #1;
        guard++;
      end
      if (!(wrReady && wrReadyR)) checkOutput("wr_ready_timeout", {wrReady, wrReadyR}, 2'b11);
      @(posedge clk); #1;
    end
    wrValid = 1'b0;
  endtask

  // Queue the expected beats of np passes over matrix sel
  task automatic pushPasses(input int sel, input int np);
    beat_t b;
    for (int p = 0; p < np; p++) begin
      for (int r = 0; r < D1; r++) begin
        for (int j = 0; j < D0; j++) begin
          b.hp[j]  = wordOf(sel, r * D0 + j);
          b.lpT[j] = lpTOf(sel, r * D0 + j);
          b.lpR[j] = lpROf(sel, r * D0 + j);
        end
        b.last = (r == D1 - 1);
        b.fin  = (p == np - 1) && (r == D1 - 1);
        expQ.push_back(b);
      end
    end
  endtask

  task automatic streamMatrix(input int sel, input int np, input logic rl);
    pushPasses(sel, np);
    applyStimulus(1'b1, rl, PW'(np));
    checkOutput("start_latency", {wValid, wValidR, busy, busyR}, 4'b1111);
  endtask

  task automatic waitDrain(input int budget);
    for (int c = 0; c < budget; c++) begin
      if (expQ.size() == 0 && !busy && !busyR) break;
      @(posedge clk); #1;
    end
    checkOutput("stream_drained", {expQ.size() == 0, busy, busyR}, 3'b100);
  endtask

  // Random consumer backpressure, changed just after each rising edge
  initial begin : readyDriver
    forever begin
      @(posedge clk); #1;
      weightReady = randomReady ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: samples on the falling edge and consumes the scoreboard
  initial begin : monitor
    beat_t                 e;
    logic [D0-1:0][OP-1:0] aHp, aHpR, stallHp;
    logic [D0-1:0][RP-1:0] aLp, aLpR, stallLp;
    bit                    stalled;
    bit                    pendDone;
    bit                    expDone;
    stalled  = 1'b0;
    pendDone = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        stalled  = 1'b0;
        pendDone = 1'b0;
        continue;
      end
      for (int j = 0; j < D0; j++) begin
        aHp[j]  = wHp[j];
        aHpR[j] = wHpR[j];
        aLp[j]  = wLp[j];
        aLpR[j] = wLpR[j];
      end
      expDone  = pendDone | doneArm;
      pendDone = 1'b0;
      doneArm  = 1'b0;
      if (expDone || done || doneR) checkOutput("done_pulse", {done, doneR}, {expDone, expDone});
      if (busy || busyR) checkOutput("wr_ready_low_in_stream", {busy, busyR, wrReady, wrReadyR}, 4'b1100);
      if (stalled) begin
        checkOutput("stall_valid_held", {wValid, wValidR}, 2'b11);
        checkOutput("stall_data_held", {aHp, aLp}, {stallHp, stallLp});
      end
      stalled = 1'b0;
      if ((wValid || wValidR) && expQ.size() == 0) begin
        checkOutput("spurious_valid", {wValid, wValidR}, 2'b00);
      end else if (wValid || wValidR) begin
        checkOutput("valid_pair", {wValid, wValidR}, 2'b11);
        if (weightReady) begin
          e = expQ.pop_front();
          checkOutput("beat_hp", {aHp, aHpR}, {e.hp, e.hp});
          checkOutput("beat_lp_trunc", aLp, e.lpT);
          checkOutput("beat_lp_round", aLpR, e.lpR);
          checkOutput("beat_last", {wLast, wLastR}, {e.last, e.last});
          pendDone = e.fin;
        end else begin
          stalled = 1'b1;
          stallHp = aHp;
          stallLp = aLp;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int guard;
    rstN        = 1'b1;
    wrData      = '0;
    wrValid     = 1'b0;
    reload      = 1'b0;
    start       = 1'b0;
    numPasses   = 8'd1;
    weightReady = 1'b1;
    #1 rstN = 1'b0;
    #2;
    checkOutput("reset_state", {wrReady, wValid, wLast, busy, done, wrReadyR, wValidR, busyR, doneR}, '0);
    #9 rstN = 1'b1;
    @(posedge clk); #1;
    checkOutput("wr_ready_after_reset", {wrReady, wrReadyR}, 2'b11);

    // Ramp matrix, single pass, consumer always ready
    loadWords(0, 0, 15);
    checkOutput("wr_ready_after_load", {wrReady, wrReadyR, busy}, 3'b000);
    streamMatrix(0, 1, 1'b0);
    waitDrain(40);

    // Reload, then quantization matrix for three passes with backpressure
    applyStimulus(1'b0, 1'b1, 8'd1);
    checkOutput("reload_to_empty", {wrReady, wrReadyR, busy}, 3'b110);
    loadWords(1, 0, 15);
    randomReady = 1'b1;
    streamMatrix(1, 3, 1'b0);
    waitDrain(300);
    randomReady = 1'b0;
    @(posedge clk); #1;

    // Zero passes: done next cycle, nothing streamed
    applyStimulus(1'b1, 1'b0, 8'd0);
    doneArm = 1'b1;
    checkOutput("np0_not_busy", {busy, busyR, wValid}, 3'b000);
    repeat (3) @(posedge clk);
    #1 checkOutput("np0_no_valid", {wValid, wValidR, busy}, 3'b000);

    // Start together with reload: start wins
    streamMatrix(1, 1, 1'b1);
    waitDrain(40);

    // Reload alone returns to EMPTY
    applyStimulus(1'b0, 1'b1, 8'd1);
    checkOutput("reload_alone", {wrReady, wrReadyR, busy}, 3'b110);

    // Reset during pass 2, row 1
    loadWords(1, 0, 15);
    streamMatrix(1, 3, 1'b0);
    guard = 0;
    while (expQ.size() > 7 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("reach_pass2_row1", {expQ.size() == 7, wValid}, 2'b11);
    #1 rstN = 1'b0;
    #1;
    checkOutput("async_abort", {wValid, busy, done, wValidR, busyR, doneR}, '0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #3 rstN = 1'b1;
    @(posedge clk); #1;
    checkOutput("empty_after_abort", {wrReady, wrReadyR, busy, done}, 4'b1100);

    // Start ignored until all 16 words are rewritten
    applyStimulus(1'b1, 1'b0, 8'd1);
    checkOutput("start_ignored_empty", {busy, busyR, wValid}, 3'b000);
    loadWords(1, 0, 14);
    applyStimulus(1'b1, 1'b0, 8'd1);
    checkOutput("start_ignored_load", {busy, busyR, wValid, wrReady}, 4'b0001);
    loadWords(1, 15, 15);
    checkOutput("reloaded_full", {wrReady, wrReadyR}, 2'b00);
    streamMatrix(1, 1, 1'b0);
    waitDrain(40);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
